// File: rtl/light_fade_driver.sv
// Lamp driver: ramps brightness linearly toward the requested on/off target and renders it as PWM.
// A target change mid-ramp reverses direction from the current brightness.
module light_fade_driver #(
    parameter int unsigned PWM_WIDTH = 8,
    parameter int unsigned STEP_DIV  = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 toglite_state,
    output logic                 pwm_out,
    output logic [PWM_WIDTH-1:0] level,
    output logic                 busy
);

    localparam logic [PWM_WIDTH-1:0] LvlMax     = {PWM_WIDTH{1'b1}};
    localparam logic [PWM_WIDTH-1:0] LvlNearMax = LvlMax - PWM_WIDTH'(1);
    localparam logic [PWM_WIDTH-1:0] LvlOne     = PWM_WIDTH'(1);
    localparam int unsigned          CntW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CntW-1:0]      StepLast   = CntW'(STEP_DIV - 1);

    localparam logic [1:0] StOff  = 2'd0;
    localparam logic [1:0] StUp   = 2'd1;
    localparam logic [1:0] StOn   = 2'd2;
    localparam logic [1:0] StDown = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [PWM_WIDTH-1:0] level_q, level_d;
    logic [CntW-1:0]      step_q, step_d;
    logic [PWM_WIDTH-1:0] pwm_cnt_q;
    logic                 pwm_q, pwm_d;
    logic                 busy_q, busy_d;
    logic                 tick;

    assign tick = (step_q == StepLast);

    // Reversal is checked before tick so a coincident step is dropped; step_cnt restarts on
    // every state change, so only the counting branches advance it.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        step_d  = '0;
        unique case (state_q)
            StOff: begin
                if (toglite_state) state_d = StUp;
            end
            StUp: begin
                if (!toglite_state) begin
                    state_d = StDown;
                end else if (tick) begin
                    if (level_q >= LvlNearMax) begin
                        level_d = LvlMax;
                        state_d = StOn;
                    end else begin
                        level_d = level_q + LvlOne;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            StOn: begin
                if (!toglite_state) state_d = StDown;
            end
            StDown: begin
                if (toglite_state) begin
                    state_d = StUp;
                end else if (tick) begin
                    if (level_q <= LvlOne) begin
                        level_d = '0;
                        state_d = StOff;
                    end else begin
                        level_d = level_q - LvlOne;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            default: begin
                state_d = StOff;
                level_d = '0;
            end
        endcase
    end

    always_comb begin
        busy_d = (state_d == StUp) || (state_d == StDown);
        pwm_d  = (level_q == LvlMax) || (pwm_cnt_q < level_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StOff;
            level_q   <= '0;
            step_q    <= '0;
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            step_q    <= step_d;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            pwm_q     <= pwm_d;
            busy_q    <= busy_d;
        end
    end

    assign pwm_out = pwm_q;
    assign level   = level_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_light_fade_driver.sv
// Directed bench for light_fade_driver: expectations queued per clock, compared after each edge.
module tb_light_fade_driver;

    localparam int unsigned PW = 4;
    localparam int unsigned SD = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          toglite_state;
    logic          pwm_out;
    logic [PW-1:0] level;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int highs;

    typedef struct {
        string    tag;
        logic [PW-1:0] lvl;
        logic     bsy;
        bit       chk_pwm;
        logic     pwm;
    } exp_t;

    exp_t sb[$];

    light_fade_driver #(.PWM_WIDTH(PW), .STEP_DIV(SD)) dut (
        .clock         (clock),
        .reset         (reset),
        .toglite_state (toglite_state),
        .pwm_out       (pwm_out),
        .level         (level),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic check_out();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard empty");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (level === e.lvl) else begin
            errors++;
            $error("FAIL %s level got %0d expected %0d", e.tag, level, e.lvl);
        end
        checks++;
        assert (busy === e.bsy) else begin
            errors++;
            $error("FAIL %s busy got %0b expected %0b", e.tag, busy, e.bsy);
        end
        if (e.chk_pwm) begin
            checks++;
            assert (pwm_out === e.pwm) else begin
                errors++;
                $error("FAIL %s pwm_out got %0b expected %0b", e.tag, pwm_out, e.pwm);
            end
        end
    endtask

    // Queue the expected post-edge outputs, advance one clock, then compare.
    task automatic step_expect(input string tag, input int lvl, input bit bsy,
                               input bit chk_pwm, input bit pwm);
        exp_t e;
        e.tag     = tag;
        e.lvl     = PW'(lvl);
        e.bsy     = bsy;
        e.chk_pwm = chk_pwm;
        e.pwm     = pwm;
        sb.push_back(e);
        @(posedge clock);
        #1;
        check_out();
    endtask

    task automatic check_highs(input string tag, input int got, input int want);
        checks++;
        assert (got == want) else begin
            errors++;
            $error("FAIL %s pwm highs got %0d expected %0d", tag, got, want);
        end
    endtask

    initial begin
        // Reset held with the target already on.
        reset         = 1'b1;
        toglite_state = 1'b1;
        for (int i = 0; i < 3; i++) step_expect("reset_hold", 0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        step_expect("enter_up", 0, 1'b1, 1'b1, 1'b0);

        // Full ramp up: one step per SD clocks, busy for 60 clocks.
        for (int k = 1; k <= 60; k++) step_expect("ramp_up", k / 4, k < 60, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) step_expect("on_hold", 15, 1'b0, 1'b1, 1'b1);

        // Full ramp down, then dark.
        toglite_state = 1'b0;
        step_expect("enter_down", 15, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 60; k++) step_expect("ramp_down", 15 - k / 4, k < 60, 1'b0, 1'b0);
        highs = 0;
        for (int k = 0; k < 16; k++) begin
            step_expect("off_hold", 0, 1'b0, 1'b1, 1'b0);
            highs += int'(pwm_out);
        end
        check_highs("duty_0", highs, 0);

        // Ramp to level 5, then toggle every clock so reversals pin the level there.
        toglite_state = 1'b1;
        step_expect("enter_up2", 0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) step_expect("ramp_to5", k / 4, 1'b1, 1'b0, 1'b0);
        highs = 0;
        for (int i = 0; i <= 16; i++) begin
            toglite_state = (i % 2 == 1);
            step_expect("glitch", 5, 1'b1, 1'b0, 1'b0);
            if (i >= 1) highs += int'(pwm_out);
        end
        check_highs("duty_5", highs, 5);

        // Reversal on a tick cycle at level 7.
        reset = 1'b1;
        step_expect("reset2", 0, 1'b0, 1'b1, 1'b0);
        reset         = 1'b0;
        toglite_state = 1'b1;
        step_expect("enter_up3", 0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 31; k++) step_expect("ramp_to7", k / 4, 1'b1, 1'b0, 1'b0);
        toglite_state = 1'b0;
        step_expect("reverse_tick", 7, 1'b1, 1'b0, 1'b0);
        for (int k = 33; k <= 36; k++)
            step_expect("reverse_step", (k < 36) ? 7 : 6, 1'b1, 1'b0, 1'b0);

        // Climb back to 9, turn down, then reset mid-DOWN.
        toglite_state = 1'b1;
        step_expect("reup", 6, 1'b1, 1'b0, 1'b0);
        for (int k = 38; k <= 49; k++) step_expect("reup_ramp", 6 + (k - 37) / 4, 1'b1, 1'b0, 1'b0);
        toglite_state = 1'b0;
        step_expect("redown", 9, 1'b1, 1'b0, 1'b0);
        step_expect("redown_hold", 9, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        step_expect("reset_mid_down", 0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        step_expect("idle_after", 0, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
